// File: rtl/dlsc_stereobm_disparity_if.sv
// SAD-beat input and best-disparity result bundle of the stereo disparity comparator.
// The master drives SAD beats; the slave (comparator) returns results and sequencing errors.
interface dlsc_stereobm_disparity_if #(
  parameter int MULT_D    = 8,
  parameter int MULT_R    = 1,
  parameter int SAD_BITS  = 16,
  parameter int DISP_BITS = 6
);

  logic                            in_valid;
  logic                            in_first;
  logic [SAD_BITS*MULT_R*MULT_D-1:0] in_sad;

  logic                            out_valid;
  logic [DISP_BITS*MULT_R-1:0]     out_disp;
  logic [SAD_BITS*MULT_R-1:0]      out_sad;
  logic                            err;

  modport master (
    output in_valid, in_first, in_sad,
    input  out_valid, out_disp, out_sad, err
  );

  modport slave (
    input  in_valid, in_first, in_sad,
    output out_valid, out_disp, out_sad, err
  );

endinterface

// File: rtl/dlsc_stereobm_disparity.sv
// Stereo block-matching disparity comparator: per-row minimum SAD over all disparity groups
// of a column, reported as the winning disparity and its SAD.
module dlsc_stereobm_disparity #(
  parameter int MULT_D      = 8,
  parameter int MULT_R      = 1,
  parameter int SAD_BITS    = 16,
  parameter int DISPARITIES = 64,
  parameter int DISP_BITS   = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  dlsc_stereobm_disparity_if.slave    bus
);

  localparam int GROUPS    = DISPARITIES / MULT_D;
  localparam int LEVELS    = $clog2(MULT_D);
  localparam int NODES     = MULT_D / 2;
  localparam int CNT_BITS  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int SLOT_BITS = LEVELS;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                state_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic                  err_q;

  logic [LEVELS-1:0]     stgValid_q;
  logic [LEVELS-1:0]     stgFirst_q;
  logic [LEVELS-1:0]     stgLast_q;
  logic [CNT_BITS-1:0]   stgGrp_q [LEVELS];

  logic [SAD_BITS-1:0]   treeSad_q [LEVELS][MULT_R][NODES];
  logic [SLOT_BITS-1:0]  treeIdx_q [LEVELS][MULT_R][NODES];

  logic [SAD_BITS-1:0]   accSad_q  [MULT_R];
  logic [SAD_BITS-1:0]   accSad_d  [MULT_R];
  logic [DISP_BITS-1:0]  accDisp_q [MULT_R];
  logic [DISP_BITS-1:0]  accDisp_d [MULT_R];

  logic                          outValid_q;
  logic [DISP_BITS*MULT_R-1:0]   outDisp_q;
  logic [SAD_BITS*MULT_R-1:0]    outSad_q;

  // Sequencer: tags each accepted beat with first/last/group as it enters the tree, and
  // shifts those tags alongside the tree levels so they meet the data at the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      stgValid_q <= '0;
      stgFirst_q <= '0;
      stgLast_q  <= '0;
      for (int l = 0; l < LEVELS; l++) begin
        stgGrp_q[l] <= '0;
      end
    end else begin
      err_q <= 1'b0;
      for (int l = LEVELS - 1; l > 0; l--) begin
        stgValid_q[l] <= stgValid_q[l-1];
        stgFirst_q[l] <= stgFirst_q[l-1];
        stgLast_q[l]  <= stgLast_q[l-1];
        stgGrp_q[l]   <= stgGrp_q[l-1];
      end
      stgValid_q[0] <= 1'b0;
      stgFirst_q[0] <= 1'b0;
      stgLast_q[0]  <= 1'b0;
      stgGrp_q[0]   <= '0;
      if (bus.in_valid) begin
        unique case (state_q)
          IDLE: begin
            if (bus.in_first) begin
              stgValid_q[0] <= 1'b1;
              stgFirst_q[0] <= 1'b1;
              if (GROUPS == 1) begin
                stgLast_q[0] <= 1'b1;
              end else begin
                cnt_q   <= CNT_BITS'(1);
                state_q <= ACCUM;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
          ACCUM: begin
            if (bus.in_first) begin
              // Restart: the new first beat reloads the accumulator, discarding the partial column.
              err_q         <= 1'b1;
              stgValid_q[0] <= 1'b1;
              stgFirst_q[0] <= 1'b1;
              cnt_q         <= CNT_BITS'(1);
            end else begin
              stgValid_q[0] <= 1'b1;
              stgGrp_q[0]   <= cnt_q;
              if (cnt_q == CNT_BITS'(GROUPS - 1)) begin
                stgLast_q[0] <= 1'b1;
                cnt_q        <= '0;
                state_q      <= IDLE;
              end else begin
                cnt_q <= cnt_q + CNT_BITS'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Pairwise min tree, one register per level; the right operand wins only when strictly
  // smaller so ties resolve to the lower slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LEVELS; l++) begin
        for (int r = 0; r < MULT_R; r++) begin
          for (int n = 0; n < NODES; n++) begin
            treeSad_q[l][r][n] <= '0;
            treeIdx_q[l][r][n] <= '0;
          end
        end
      end
    end else begin
      for (int r = 0; r < MULT_R; r++) begin
        for (int n = 0; n < NODES; n++) begin
          if (bus.in_sad[(2*n+1+r*MULT_D)*SAD_BITS +: SAD_BITS] <
              bus.in_sad[(2*n+r*MULT_D)*SAD_BITS +: SAD_BITS]) begin
            treeSad_q[0][r][n] <= bus.in_sad[(2*n+1+r*MULT_D)*SAD_BITS +: SAD_BITS];
            treeIdx_q[0][r][n] <= SLOT_BITS'(2*n+1);
          end else begin
            treeSad_q[0][r][n] <= bus.in_sad[(2*n+r*MULT_D)*SAD_BITS +: SAD_BITS];
            treeIdx_q[0][r][n] <= SLOT_BITS'(2*n);
          end
        end
      end
      for (int l = 1; l < LEVELS; l++) begin
        for (int r = 0; r < MULT_R; r++) begin
          for (int n = 0; n < (NODES >> l); n++) begin
            if (treeSad_q[l-1][r][2*n+1] < treeSad_q[l-1][r][2*n]) begin
              treeSad_q[l][r][n] <= treeSad_q[l-1][r][2*n+1];
              treeIdx_q[l][r][n] <= treeIdx_q[l-1][r][2*n+1];
            end else begin
              treeSad_q[l][r][n] <= treeSad_q[l-1][r][2*n];
              treeIdx_q[l][r][n] <= treeIdx_q[l-1][r][2*n];
            end
          end
        end
      end
    end
  end

  // MULT_D is a power of two, so disparity g*MULT_D+j is just {group, slot}.
  always_comb begin
    for (int r = 0; r < MULT_R; r++) begin
      accSad_d[r]  = accSad_q[r];
      accDisp_d[r] = accDisp_q[r];
      if (stgValid_q[LEVELS-1] &&
          (stgFirst_q[LEVELS-1] || (treeSad_q[LEVELS-1][r][0] < accSad_q[r]))) begin
        accSad_d[r]  = treeSad_q[LEVELS-1][r][0];
        accDisp_d[r] = DISP_BITS'({stgGrp_q[LEVELS-1], treeIdx_q[LEVELS-1][r][0]});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outDisp_q  <= '0;
      outSad_q   <= '0;
      for (int r = 0; r < MULT_R; r++) begin
        accSad_q[r]  <= '0;
        accDisp_q[r] <= '0;
      end
    end else begin
      outValid_q <= stgValid_q[LEVELS-1] & stgLast_q[LEVELS-1];
      for (int r = 0; r < MULT_R; r++) begin
        accSad_q[r]  <= accSad_d[r];
        accDisp_q[r] <= accDisp_d[r];
        if (stgValid_q[LEVELS-1] && stgLast_q[LEVELS-1]) begin
          outSad_q[r*SAD_BITS +: SAD_BITS]    <= accSad_d[r];
          outDisp_q[r*DISP_BITS +: DISP_BITS] <= accDisp_d[r];
        end
      end
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_disp  = outDisp_q;
  assign bus.out_sad   = outSad_q;
  assign bus.err       = err_q;

endmodule
